// File: rtl/conv_addr_gen.sv
// conv_addr_gen: sliding-window address generator for a KxK convolution over
// a C-channel W x H image stored channel-plane after channel-plane.
// For every output window it emits the C*k*k tap addresses (channel, then
// kernel row, then kernel column) under a valid/ready handshake, then spends
// one SLIDE cycle strobing the output-map address of the finished window.
// Optional feature macro: CONV_ZERO_PAD_EN (zero-padded "same" convolution;
// out-of-image taps are emitted with img_pad=1 and img_addr=0).
module conv_addr_gen #(
  parameter int W      = 220,
  parameter int H      = 220,
  parameter int C      = 1,
  parameter int K_MAX  = 7,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [3:0]        k,
  input  logic [1:0]        stride,
  input  logic              ready,
  output logic [ADDR_W-1:0] img_addr,
  output logic              img_valid,
  output logic              img_pad,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_valid,
  output logic              ker_complete,
  output logic              conv_complete,
  output logic              busy,
  output logic              err
);

  localparam int CHW = (C > 1) ? $clog2(C) : 1;
  localparam int XW  = $clog2((W > H) ? W : H) + 2;
  // Largest kernel that is both configured and fits inside the image.
  localparam int KLIM = (K_MAX < W) ? ((K_MAX < H) ? K_MAX : H) : ((W < H) ? W : H);
  localparam longint KLIM_L = longint'(KLIM);
  localparam longint WL     = longint'(W);
  localparam longint HL     = longint'(H);
  localparam longint CL     = longint'(C);

  typedef enum logic [1:0] {IDLE, FETCH, SLIDE, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic [1:0]          stride_q, stride_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic [3:0]          kr_q, kr_d;
  logic [3:0]          kc_q, kc_d;
  // Window origin relative to the first window (multiples of stride).
  logic [XW-1:0]       wx_q, wx_d;
  logic [XW-1:0]       wy_q, wy_d;
  logic [ADDR_W-1:0]   win_q, win_d;
  logic [ADDR_W-1:0]   img_addr_q, img_addr_d;
  logic                img_valid_q, img_valid_d;
  logic                img_pad_q, img_pad_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
  logic                res_valid_q, res_valid_d;
  logic                ker_complete_q, ker_complete_d;
  logic                conv_complete_q, conv_complete_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                legal;
  logic                last_tap;
  logic                row_end;
  logic                col_end;
  longint              org_start;
  longint              org_cur;
  longint              span_x;
  longint              span_y;
`ifdef CONV_ZERO_PAD_EN
  logic [3:0]          km1_start;
  logic [3:0]          km1_cur;
`endif

  // Tap address and pad flag; full-width arithmetic, truncated only at the end.
  function automatic logic [ADDR_W:0] tap_calc(input longint ch, input longint kr,
                                               input longint kc, input longint wy,
                                               input longint wx, input longint org);
    longint y;
    longint x;
    longint a;
    logic   pad;
    y = wy + kr - org;
    x = wx + kc - org;
`ifdef CONV_ZERO_PAD_EN
    pad = (y < 64'sd0) || (y >= HL) || (x < 64'sd0) || (x >= WL);
`else
    pad = 1'b0;
`endif
    a = '0;
    if (!pad) begin
      a = ch * WL * HL + y * WL + x;
    end
    return {pad, a[ADDR_W-1:0]};
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    stride_d        = stride_q;
    ch_d            = ch_q;
    kr_d            = kr_q;
    kc_d            = kc_q;
    wx_d            = wx_q;
    wy_d            = wy_q;
    win_d           = win_q;
    img_addr_d      = img_addr_q;
    img_valid_d     = img_valid_q;
    img_pad_d       = img_pad_q;
    res_addr_d      = res_addr_q;
    res_valid_d     = 1'b0;
    ker_complete_d  = 1'b0;
    conv_complete_d = conv_complete_q;
    busy_d          = busy_q;
    err_d           = 1'b0;

`ifdef CONV_ZERO_PAD_EN
    // Padded mode centres the kernel: origin -(k-1)/2, one window per stride step.
    km1_start = k - 4'd1;
    km1_cur   = k_q - 4'd1;
    org_start = longint'(km1_start >> 1);
    org_cur   = longint'(km1_cur >> 1);
    span_x    = WL - 64'sd1;
    span_y    = HL - 64'sd1;
`else
    org_start = '0;
    org_cur   = '0;
    span_x    = WL - longint'(k_q);
    span_y    = HL - longint'(k_q);
`endif

    legal    = (k != 4'd0) && (longint'(k) <= KLIM_L) && (stride != 2'd0);
    last_tap = (longint'(ch_q) == CL - 64'sd1) && (kr_q == k_q - 4'd1) && (kc_q == k_q - 4'd1);
    row_end  = (longint'(wx_q) + longint'(stride_q)) > span_x;
    col_end  = (longint'(wy_q) + longint'(stride_q)) > span_y;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (legal) begin
            state_d         = FETCH;
            k_d             = k;
            stride_d        = stride;
            ch_d            = '0;
            kr_d            = '0;
            kc_d            = '0;
            wx_d            = '0;
            wy_d            = '0;
            win_d           = '0;
            busy_d          = 1'b1;
            conv_complete_d = 1'b0;
            img_valid_d     = 1'b1;
            {img_pad_d, img_addr_d} = tap_calc(64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, org_start);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (ready) begin
          if (last_tap) begin
            // Strobes are registered here so they are visible during SLIDE.
            state_d        = SLIDE;
            img_valid_d    = 1'b0;
            ker_complete_d = 1'b1;
            res_valid_d    = 1'b1;
            res_addr_d     = win_q;
            win_d          = win_q + ADDR_W'(1);
          end else begin
            if (kc_q != k_q - 4'd1) begin
              kc_d = kc_q + 4'd1;
            end else begin
              kc_d = '0;
              if (kr_q != k_q - 4'd1) begin
                kr_d = kr_q + 4'd1;
              end else begin
                kr_d = '0;
                ch_d = ch_q + CHW'(1);
              end
            end
            {img_pad_d, img_addr_d} = tap_calc(longint'(ch_d), longint'(kr_d), longint'(kc_d),
                                               longint'(wy_q), longint'(wx_q), org_cur);
          end
        end
      end
      SLIDE: begin
        ch_d = '0;
        kr_d = '0;
        kc_d = '0;
        if (row_end && col_end) begin
          state_d         = DONE;
          busy_d          = 1'b0;
          conv_complete_d = 1'b1;
        end else begin
          if (row_end) begin
            wx_d = '0;
            wy_d = wy_q + XW'(stride_q);
          end else begin
            wx_d = wx_q + XW'(stride_q);
          end
          state_d     = FETCH;
          img_valid_d = 1'b1;
          {img_pad_d, img_addr_d} = tap_calc(64'sd0, 64'sd0, 64'sd0,
                                             longint'(wy_d), longint'(wx_d), org_cur);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and outputs; asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      k_q             <= '0;
      stride_q        <= '0;
      ch_q            <= '0;
      kr_q            <= '0;
      kc_q            <= '0;
      wx_q            <= '0;
      wy_q            <= '0;
      win_q           <= '0;
      img_addr_q      <= '0;
      img_valid_q     <= 1'b0;
      img_pad_q       <= 1'b0;
      res_addr_q      <= '0;
      res_valid_q     <= 1'b0;
      ker_complete_q  <= 1'b0;
      conv_complete_q <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      stride_q        <= stride_d;
      ch_q            <= ch_d;
      kr_q            <= kr_d;
      kc_q            <= kc_d;
      wx_q            <= wx_d;
      wy_q            <= wy_d;
      win_q           <= win_d;
      img_addr_q      <= img_addr_d;
      img_valid_q     <= img_valid_d;
      img_pad_q       <= img_pad_d;
      res_addr_q      <= res_addr_d;
      res_valid_q     <= res_valid_d;
      ker_complete_q  <= ker_complete_d;
      conv_complete_q <= conv_complete_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
    end
  end

  assign img_addr      = img_addr_q;
  assign img_valid     = img_valid_q;
  assign img_pad       = img_pad_q;
  assign res_addr      = res_addr_q;
  assign res_valid     = res_valid_q;
  assign ker_complete  = ker_complete_q;
  assign conv_complete = conv_complete_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: doc/conv_addr_gen.md
CONV_ADDR_GEN -- requirements
Module: conv_addr_gen

Interface
REQ-001 Parameter W, default 220: input image width in pixels.
REQ-002 Parameter H, default 220: input image height in pixels.
REQ-003 Parameter C, default 1: input channel count; channel planes stored back to back, each W*H words.
REQ-004 Parameter K_MAX, default 7: largest accepted kernel size.
REQ-005 Parameter ADDR_W, default 16: address width; C*W*H SHALL be at most 2^ADDR_W.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rstn  in  1  reset; asynchronous, active-low.
REQ-008 start  in  1  launches a convolution pass; sampled only in IDLE and DONE.
REQ-009 k  in  4  kernel size, sampled with start; legal range 1..K_MAX and k<=min(W,H).
REQ-010 stride  in  2  window step, sampled with start; legal range 1..3.
REQ-011 ready  in  1  downstream accepts the current img_addr.
REQ-012 img_addr  out  ADDR_W  image-memory address of the current kernel tap.
REQ-013 img_valid  out  1  img_addr and img_pad are valid.
REQ-014 img_pad  out  1  current tap lies outside the image; consumer substitutes zero.
REQ-015 res_addr  out  ADDR_W  output-map address of the window just finished: out_row*OW + out_col.
REQ-016 res_valid  out  1  one-cycle strobe qualifying res_addr.
REQ-017 ker_complete  out  1  one-cycle strobe at the end of each window.
REQ-018 conv_complete  out  1  level; the whole pass is finished.
REQ-019 busy  out  1  high in FETCH and SLIDE.
REQ-020 err  out  1  one-cycle strobe when start is sampled with illegal k or stride.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, SLIDE and DONE.
REQ-022 IDLE/DONE: start with legal k and stride -> FETCH next cycle; start with illegal k or stride -> err for one cycle, state unchanged.
REQ-023 img_valid SHALL be high throughout FETCH; the first tap is presented in the cycle after start is sampled.
REQ-024 Tap order within a window SHALL be channel outermost (0..C-1), then kernel row, then kernel column.
REQ-025 Tap address SHALL be ch*W*H + (oy+kr)*W + (ox+kc), computed without truncation before the final ADDR_W result.
REQ-026 The tap SHALL advance only on img_valid&&ready; while ready is low, img_addr and img_pad SHALL hold.
REQ-027 After the last tap's handshake, SLIDE SHALL last exactly one cycle, with ker_complete=1, res_valid=1 and res_addr set.
REQ-028 SLIDE SHALL step ox by stride; at the row end it SHALL reset ox and step oy by stride.
REQ-029 After SLIDE for the last window, the FSM SHALL enter DONE; otherwise it SHALL return to FETCH.
REQ-030 Output dimensions without padding: OW=(W-k)/stride+1 and OH=(H-k)/stride+1, integer division.
REQ-031 DONE SHALL hold conv_complete=1 until a legal start, which clears it in the same cycle FETCH is entered.
REQ-032 start during FETCH or SLIDE SHALL be ignored.

Reset
REQ-033 rstn low SHALL immediately force IDLE and zero every output and every counter, including mid-pass.
REQ-034 After rstn deasserts, no output SHALL change until a start is sampled.

Configuration
REQ-035 Macro CONV_ZERO_PAD_EN defined: windows start at oy=ox=-(k-1)/2, with OW=(W-1)/stride+1 and OH=(H-1)/stride+1.
REQ-036 With CONV_ZERO_PAD_EN, out-of-image taps SHALL be emitted with img_pad=1 and img_addr=0, consuming a handshake like any other tap.
REQ-037 Macro CONV_ZERO_PAD_EN undefined: valid-only convolution per REQ-030; img_pad is tied 0.

Verification
REQ-038 Parameters W=8, H=8, C=2; start with k=3, stride=1 -> taps 0,1,2,8,9,10,16,17,18,64,65,66,72,73,74,80,81,82; then ker_complete with res_addr=0.
REQ-039 Same setup run to completion -> exactly 36 res_valid pulses with res_addr 0..35 in order; conv_complete=1 after the final SLIDE.
REQ-040 Same setup with stride=2 -> 9 windows; the second window's first tap is 2; the fourth window's first tap is 16.
REQ-041 Hold ready low for 3 cycles on the 5th tap -> img_addr stays at 9 throughout; no tap is skipped or duplicated.
REQ-042 start with k=0, k=9 or stride=0 -> err pulse, busy stays 0; assert rstn low mid-window -> all outputs 0 in the same cycle, state IDLE.
REQ-043 CONV_ZERO_PAD_EN, W=H=8, C=1, k=3, stride=1 -> first window taps 1-4 and 7 have img_pad=1; tap 5 has addr 0, pad 0; 64 windows total.
